// File: rtl/updown_counter_mod_if.sv
// Bus bundle for one updown_counter_mod stage: control/load inputs and count/cascade outputs.
interface updown_counter_mod_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic             en;
  logic             ci;
  logic             dn;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             co;
  logic             ovf;

  modport master (
    output load, en, ci, dn, d,
    input  q, co, ovf
  );

  modport slave (
    input  load, en, ci, dn, d,
    output q, co, ovf
  );
endinterface

// File: rtl/updown_counter_mod.sv
// Programmable-modulus up/down counter stage with load, cascade carry and sticky overflow.
// Define UDC_SATURATE_EN to make the counter hold at the terminal value instead of wrapping.
module updown_counter_mod #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic                 clk,
  input  logic                 mr_n,
  updown_counter_mod_if.slave  bus
);

  localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_EXT = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE_EXT = (WIDTH + 1)'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   d_ext;
  logic [WIDTH:0]   tc;
  logic [WIDTH:0]   nxt;
  logic             step;
  logic             at_tc;
  logic             wrap;

  always_comb begin
    q_ext = {1'b0, q_q};
    d_ext = {1'b0, bus.d};
    tc    = bus.dn ? '0 : MAX_EXT;
    at_tc = (q_ext == tc);
    step  = bus.en & bus.ci & ~bus.load;
    nxt   = bus.dn ? (q_ext - ONE_EXT) : (q_ext + ONE_EXT);
    // Extra bit exposes the borrow on down-count; up-wrap compares to MODULUS, not 2**WIDTH.
    wrap  = bus.dn ? nxt[WIDTH] : (nxt == MOD_EXT);

    q_d   = q_q;
    ovf_d = ovf_q;
    if (bus.load) begin
      q_d   = (d_ext > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : bus.d;
      ovf_d = 1'b0;
    end else if (step) begin
      if (wrap) begin
        ovf_d = 1'b1;
`ifdef UDC_SATURATE_EN
        q_d   = q_q;
`else
        q_d   = bus.dn ? MAX_EXT[WIDTH-1:0] : '0;
`endif
      end else begin
        q_d = nxt[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge mr_n) begin
    if (!mr_n) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.q   = q_q;
  assign bus.ovf = ovf_q;
  assign bus.co  = step & at_tc;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Scoreboard bench: a single BCD stage plus a two-digit BCD cascade against a digit-level model.
module tb_updown_counter_mod;

  localparam int M = 10;
`ifdef UDC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic mr_n;

  updown_counter_mod_if #(.WIDTH(4)) s_if ();
  updown_counter_mod_if #(.WIDTH(4)) cu_if ();
  updown_counter_mod_if #(.WIDTH(4)) ct_if ();

  updown_counter_mod #(.WIDTH(4), .MODULUS(10)) u_single (.clk(clk), .mr_n(mr_n), .bus(s_if));
  updown_counter_mod #(.WIDTH(4), .MODULUS(10)) u_units  (.clk(clk), .mr_n(mr_n), .bus(cu_if));
  updown_counter_mod #(.WIDTH(4), .MODULUS(10)) u_tens   (.clk(clk), .mr_n(mr_n), .bus(ct_if));

  assign ct_if.ci   = cu_if.co;
  assign ct_if.en   = cu_if.en;
  assign ct_if.dn   = cu_if.dn;
  assign ct_if.load = cu_if.load;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit s_co; int s_q; bit s_ovf;
    bit u_co; int u_q; bit u_ovf;
    bit t_co; int t_q; bit t_ovf;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  int m_s, m_u, m_t;
  bit m_sovf, m_uovf, m_tovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: one decade digit stepped by plain integer arithmetic.
  task automatic digit_step(input int dig, input bit ovf, input bit c, input bit ld,
                            input int dv, input bit dn,
                            output int ndig, output bit novf, output bit co);
    int nx;
    ndig = dig;
    novf = ovf;
    co   = 1'b0;
    if (ld) begin
      ndig = (dv > M - 1) ? M - 1 : dv;
      novf = 1'b0;
    end else begin
      co = c && (dn ? (dig == 0) : (dig == M - 1));
      if (c) begin
        nx = dn ? dig - 1 : dig + 1;
        if (nx < 0 || nx >= M) begin
          novf = 1'b1;
          nx   = SAT ? dig : (nx + M) % M;
        end
        ndig = nx;
      end
    end
  endtask

  task automatic model_reset();
    m_s = 0; m_u = 0; m_t = 0;
    m_sovf = 1'b0; m_uovf = 1'b0; m_tovf = 1'b0;
  endtask

  task automatic apply(input bit ld, input bit en, input bit ci, input bit dn, input logic [3:0] d,
                       input bit cld, input bit cen, input bit cdn, input logic [7:0] cd);
    exp_t e;
    bit   uco;
    @(negedge clk);
    s_if.load  = ld;  s_if.en = en;  s_if.ci = ci;  s_if.dn = dn;  s_if.d = d;
    cu_if.load = cld; cu_if.en = cen; cu_if.dn = cdn;
    cu_if.d    = cd[3:0];
    ct_if.d    = cd[7:4];
    #1;
    digit_step(m_s, m_sovf, en & ci, ld, int'(d), dn, e.s_q, e.s_ovf, e.s_co);
    digit_step(m_u, m_uovf, cen, cld, int'(cd[3:0]), cdn, e.u_q, e.u_ovf, uco);
    e.u_co = uco;
    digit_step(m_t, m_tovf, cen & uco, cld, int'(cd[7:4]), cdn, e.t_q, e.t_ovf, e.t_co);
    m_s = e.s_q; m_sovf = e.s_ovf;
    m_u = e.u_q; m_uovf = e.u_ovf;
    m_t = e.t_q; m_tovf = e.t_ovf;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    s_if.load = 1'b0; s_if.en = 1'b0; s_if.ci = 1'b0; s_if.dn = 1'b0; s_if.d = '0;
    cu_if.load = 1'b0; cu_if.en = 1'b0; cu_if.dn = 1'b0; cu_if.d = '0; ct_if.d = '0;
  endtask

  // Monitor: combinational co checked mid-cycle, registered q/ovf just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("s_co", 32'(s_if.co),  32'(e.s_co));
        check("u_co", 32'(cu_if.co), 32'(e.u_co));
        check("t_co", 32'(ct_if.co), 32'(e.t_co));
        @(posedge clk);
        #1;
        check("s_q",   32'(s_if.q),    e.s_q);
        check("s_ovf", 32'(s_if.ovf),  32'(e.s_ovf));
        check("u_q",   32'(cu_if.q),   e.u_q);
        check("u_ovf", 32'(cu_if.ovf), 32'(e.u_ovf));
        check("t_q",   32'(ct_if.q),   e.t_q);
        check("t_ovf", 32'(ct_if.ovf), 32'(e.t_ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mr_n = 1'b0;
    cu_if.ci = 1'b1;
    idle_inputs();
    model_reset();
    #3;
    check("rst_q",   32'(s_if.q),   0);
    check("rst_ovf", 32'(s_if.ovf), 0);
    check("rst_co",  32'(s_if.co),  0);
    check("rst_cq",  32'({ct_if.q, cu_if.q}), 0);
    s_if.en = 1'b1; s_if.ci = 1'b1; s_if.dn = 1'b1;
    #1;
    check("rst_co_dn", 32'(s_if.co), 1);
    idle_inputs();
    @(negedge clk);
    mr_n = 1'b1;

    // Asynchronous reset mid-cycle from q=7 with en high.
    apply(1, 0, 0, 0, 4'd7, 0, 0, 0, 8'h00);
    @(posedge clk); #2;
    s_if.load = 1'b0; s_if.en = 1'b1; s_if.ci = 1'b1; s_if.dn = 1'b0;
    mr_n = 1'b0;
    #1;
    check("async_q",   32'(s_if.q),   0);
    check("async_ovf", 32'(s_if.ovf), 0);
    model_reset();
    s_if.en = 1'b0;
    @(negedge clk);
    mr_n = 1'b1;
    apply(0, 1, 1, 0, 4'd0, 0, 0, 0, 8'h00);

    // BCD up-wrap.
    apply(1, 0, 0, 0, 4'd0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) apply(0, 1, 1, 0, 4'd0, 0, 0, 0, 8'h00);
    // Priority: wrap down to 9 with ovf set, then load+en together.
    apply(0, 1, 1, 1, 4'd0, 0, 0, 0, 8'h00);
    apply(1, 1, 1, 0, 4'd3, 0, 0, 0, 8'h00);
    // Clamp load and down-wrap.
    apply(1, 0, 0, 0, 4'hF, 0, 0, 0, 8'h00);
    for (int i = 0; i < 11; i++) apply(0, 1, 1, 1, 4'd0, 0, 0, 0, 8'h00);
    // Saturation/wrap at both terminals.
    apply(1, 0, 0, 0, 4'd9, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) apply(0, 1, 1, 0, 4'd0, 0, 0, 0, 8'h00);
    apply(1, 0, 0, 0, 4'd0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 2; i++) apply(0, 1, 1, 1, 4'd0, 0, 0, 0, 8'h00);

    // co follows dn combinationally at q=0.
    apply(1, 0, 0, 0, 4'd0, 0, 0, 0, 8'h00);
    @(posedge clk); #2;
    s_if.load = 1'b0; s_if.en = 1'b1; s_if.ci = 1'b1; s_if.dn = 1'b0;
    #1;
    check("co_dn0", 32'(s_if.co), 0);
    s_if.dn = 1'b1;
    #1;
    check("co_dn1", 32'(s_if.co), 1);
    s_if.en = 1'b0;

    // Two-digit cascade.
    apply(0, 0, 0, 0, 4'd0, 1, 0, 0, 8'h09);
    apply(0, 0, 0, 0, 4'd0, 0, 1, 0, 8'h00);
    apply(0, 0, 0, 0, 4'd0, 1, 0, 0, 8'h99);
    apply(0, 0, 0, 0, 4'd0, 0, 1, 0, 8'h00);
    apply(0, 0, 0, 0, 4'd0, 1, 0, 0, 8'h00);
    apply(0, 0, 0, 0, 4'd0, 0, 1, 1, 8'h00);

    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 7) == 0, 1'($urandom), $urandom_range(0, 3) != 0, 1'($urandom),
            4'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) == 0, 8'($urandom));
    end

    // Reset asserted while a load is pending: reset wins.
    @(posedge clk); #2;
    @(negedge clk);
    s_if.load = 1'b1; s_if.d = 4'd5; s_if.en = 1'b1;
    cu_if.load = 1'b1; cu_if.d = 4'd5; ct_if.d = 4'd5;
    #2;
    mr_n = 1'b0;
    @(posedge clk); #1;
    check("rst_ld_q",   32'(s_if.q),   0);
    check("rst_ld_ovf", 32'(s_if.ovf), 0);
    check("rst_ld_cq",  32'({ct_if.q, cu_if.q}), 0);
    idle_inputs();
    model_reset();
    @(negedge clk);
    mr_n = 1'b1;
    apply(0, 1, 1, 1, 4'd0, 0, 1, 1, 8'h00);
    @(posedge clk); #3;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
